// File: rtl/imm_gen_pipe.sv
// Pipelined RV32I/RV64I immediate generator: decodes format, immediate, illegal flag
// and pc-relative target, behind a valid/ready output stage with optional skid buffer.
module imm_gen_pipe #(
    parameter int XLEN = 32,
    parameter bit SKID = 1'b1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic [XLEN-1:0] out_target,
    output logic            out_illegal
);

    localparam bit RV64 = (XLEN == 64);

    localparam logic [2:0] FMT_NONE = 3'd0;
    localparam logic [2:0] FMT_I    = 3'd1;
    localparam logic [2:0] FMT_S    = 3'd2;
    localparam logic [2:0] FMT_B    = 3'd3;
    localparam logic [2:0] FMT_U    = 3'd4;
    localparam logic [2:0] FMT_J    = 3'd5;
    localparam logic [2:0] FMT_ZIMM = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_IMM32  = 7'b0011011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;
    localparam logic [6:0] OP_OP     = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_OP32   = 7'b0111011;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic [XLEN-1:0] target;
        logic            illegal;
    } beat_t;

    beat_t              dec;
    beat_t              out_q;
    logic signed [31:0] imm32;
    logic [2:0]         fmt;
    logic               illegal;
    logic               pcrel;
    logic               accept;
    logic               out_free;

    // Every RV immediate fits in 32 signed bits; the size cast sign-extends to XLEN.
    always_comb begin
        imm32   = '0;
        fmt     = FMT_NONE;
        illegal = 1'b0;
        pcrel   = 1'b0;
        case (in_instr[6:0])
            OP_LOAD, OP_IMM, OP_JALR: begin
                fmt   = FMT_I;
                imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
            end
            OP_IMM32: begin
                if (RV64) begin
                    fmt   = FMT_I;
                    imm32 = {{20{in_instr[31]}}, in_instr[31:20]};
                end else begin
                    illegal = 1'b1;
                end
            end
            OP_STORE: begin
                fmt   = FMT_S;
                imm32 = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OP_BRANCH: begin
                fmt   = FMT_B;
                pcrel = 1'b1;
                imm32 = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                         in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt   = FMT_U;
                pcrel = (in_instr[6:0] == OP_AUIPC);
                imm32 = {in_instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt   = FMT_J;
                pcrel = 1'b1;
                imm32 = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                         in_instr[20], in_instr[30:21], 1'b0};
            end
            OP_SYSTEM: begin
                if (in_instr[14]) begin
                    fmt   = FMT_ZIMM;
                    imm32 = {27'b0, in_instr[19:15]};
                end
            end
            OP_OP, OP_FENCE: ;
            OP_OP32: illegal = ~RV64;
            default: illegal = 1'b1;
        endcase
    end

    always_comb begin
        dec.imm     = XLEN'(imm32);
        dec.fmt     = fmt;
        dec.illegal = illegal;
        dec.target  = pcrel ? (in_pc + XLEN'(imm32)) : '0;
    end

    assign accept   = in_valid & in_ready;
    assign out_free = ~out_valid | out_ready;

    if (SKID) begin : g_skid
        beat_t skid_q;
        logic  skid_valid;

        assign in_ready = ~skid_valid;

        // A stalled output parks the incoming beat in skid; skid drains before new input.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_valid  <= 1'b0;
                out_q      <= '0;
                skid_valid <= 1'b0;
                skid_q     <= '0;
            end else if (flush) begin
                out_valid  <= 1'b0;
                skid_valid <= 1'b0;
            end else if (out_free) begin
                if (skid_valid) begin
                    out_q      <= skid_q;
                    out_valid  <= 1'b1;
                    skid_valid <= 1'b0;
                end else begin
                    out_valid <= accept;
                    if (accept) out_q <= dec;
                end
            end else if (accept) begin
                skid_q     <= dec;
                skid_valid <= 1'b1;
            end
        end
    end else begin : g_noskid
        assign in_ready = out_free;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                out_valid <= 1'b0;
                out_q     <= '0;
            end else if (flush) begin
                out_valid <= 1'b0;
            end else if (accept) begin
                out_q     <= dec;
                out_valid <= 1'b1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

    assign out_imm     = out_q.imm;
    assign out_fmt     = out_q.fmt;
    assign out_target  = out_q.target;
    assign out_illegal = out_q.illegal;

endmodule
